// File: rtl/bp_be_pkg.sv
// ============================================================================
// Module : bp_be_pkg
// Brief  : Shared backend types and queue-depth constants.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_be_pkg;

  // Default FE queue depth taken from the active parameter set
  localparam int c_fe_queue_fifo_els = 8;

  typedef enum logic [1:0] {
    e_run  = 2'd0,
    e_roll = 2'd1,
    e_clr  = 2'd2
  } bp_be_fe_queue_ctrl_state_e;

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_counter_up_down.sv
// ============================================================================
// Module : bsg_counter_up_down
// Brief  : Up/down counter with async reset and synchronous clear.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bsg_counter_up_down #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             up_i,
  input  logic             down_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_up;
  logic [WIDTH-1:0] w_down;

  assign w_up   = {{(WIDTH-1){1'b0}}, up_i};
  assign w_down = {{(WIDTH-1){1'b0}}, down_i};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + w_up - w_down;
    end
  end

  assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/bp_be_fe_queue_ctrl.sv
// ============================================================================
// Module : bp_be_fe_queue_ctrl
// Brief  : FE queue sequencer: issue/commit strobes and roll/clear flush FSM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_be_fe_queue_ctrl
  import bp_be_pkg::*;
#(
  parameter  int fifo_els_p        = c_fe_queue_fifo_els,
  localparam int inflight_width_lp = safe_clog2(fifo_els_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         queue_v_i,
  input  logic                         issue_v_i,
  input  logic                         commit_v_i,
  input  logic                         replay_v_i,
  input  logic                         redirect_v_i,
  input  logic                         fe_ack_i,
  output logic                         issue_en_o,
  output logic                         yumi_o,
  output logic                         deq_v_o,
  output logic                         roll_v_o,
  output logic                         clr_v_o,
  output logic [inflight_width_lp-1:0] inflight_o,
  output logic                         busy_o,
  output logic                         error_o
);

  localparam logic [inflight_width_lp-1:0] c_inflight_max = inflight_width_lp'(fifo_els_p);

  bp_be_fe_queue_ctrl_state_e r_state;
  logic                       r_replay_only;
  logic                       r_error;

  logic [inflight_width_lp-1:0] w_inflight;
  logic                         w_issue_en;
  logic                         w_yumi;
  logic                         w_deq;
  logic                         w_in_roll;
  logic                         w_bad_issue;
  logic                         w_bad_commit;

  assign w_in_roll  = (r_state == e_roll);
  assign w_issue_en = (r_state == e_run) & queue_v_i & ~replay_v_i & ~redirect_v_i
                    & (w_inflight < c_inflight_max);
  assign w_yumi     = issue_v_i & w_issue_en;
  assign w_deq      = commit_v_i & (w_inflight != '0);

  assign w_bad_issue  = issue_v_i & ~w_issue_en;
  assign w_bad_commit = commit_v_i & (w_inflight == '0);

  // Roll rewinds the read pointer to the commit pointer, so nothing stays in flight
  bsg_counter_up_down #(
    .WIDTH (inflight_width_lp)
  ) u_inflight_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (w_in_roll),
    .up_i    (w_yumi),
    .down_i  (w_deq),
    .count_o (w_inflight)
  );

  // Redirect from any state restarts the flush at roll and drops replay-only
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= e_run;
      r_replay_only <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      if (w_bad_issue | w_bad_commit) begin
        r_error <= 1'b1;
      end
      case (r_state)
        e_run: begin
          if (redirect_v_i) begin
            r_state       <= e_roll;
            r_replay_only <= 1'b0;
          end else if (replay_v_i) begin
            r_state       <= e_roll;
            r_replay_only <= 1'b1;
          end
        end
        e_roll: begin
          if (redirect_v_i) begin
            r_state       <= e_roll;
            r_replay_only <= 1'b0;
          end else if (r_replay_only) begin
            r_state       <= e_run;
            r_replay_only <= 1'b0;
          end else begin
            r_state <= e_clr;
          end
        end
        e_clr: begin
          if (redirect_v_i) begin
            r_state       <= e_roll;
            r_replay_only <= 1'b0;
          end else if (fe_ack_i) begin
            r_state <= e_run;
          end
        end
        default: begin
          r_state       <= e_run;
          r_replay_only <= 1'b0;
        end
      endcase
    end
  end

  assign issue_en_o = w_issue_en;
  assign yumi_o     = w_yumi;
  assign deq_v_o    = w_deq;
  assign roll_v_o   = w_in_roll;
  assign clr_v_o    = (r_state == e_clr);
  assign busy_o     = (r_state != e_run);
  assign error_o    = r_error;
  assign inflight_o = w_inflight;

endmodule

`default_nettype wire

// File: doc/bp_be_fe_queue_ctrl.md
Name: bp_be_fe_queue_ctrl

Overview:
- Sequencer for the backend's rollback-capable FE queue (the rolly FIFO).
- Turns pipeline events (issue, commit, replay, redirect) into the queue's read-acknowledge (yumi), dequeue, roll and clear strobes.
- Tracks issued-but-uncommitted instructions and runs the multi-cycle redirect flush (roll, then clear, then wait for FE acknowledge).
- Sits between the scheduler/commit logic and the queue, inside bp_be_scheduler.

Parameters:
fifo_els_p, 8, FE queue depth; bounds the in-flight count (derived from fe_queue_fifo_els_p of bp_params_p)
inflight_width_lp, `BSG_SAFE_CLOG2(fifo_els_p+1), local; in-flight counter width

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
queue_v_i  in  1  queue has a valid entry (fe_queue_v_o of queue)
issue_v_i  in  1  scheduler consumes the head entry; legal only when issue_en_o=1
commit_v_i  in  1  oldest in-flight instruction retired
replay_v_i  in  1  pipeline flush; all uncommitted instructions must re-issue
redirect_v_i  in  1  mispredict/exception; all queued and uncommitted entries are discarded
fe_ack_i  in  1  frontend has accepted the redirect; enqueue may resume
issue_en_o  out  1  scheduler may issue this cycle
yumi_o  out  1  to queue fe_queue_yumi_i
deq_v_o  out  1  to queue deq_v_i
roll_v_o  out  1  to queue roll_v_i
clr_v_o  out  1  to queue clr_v_i
inflight_o  out  inflight_width_lp  issued-uncommitted count
busy_o  out  1  state != e_run
error_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (async): state=e_run, inflight=0, error=0.
- Outputs after reset: roll_v_o=clr_v_o=deq_v_o=yumi_o=busy_o=error_o=0; inflight_o=0.
- States: e_run, e_roll, e_clr.
- issue_en_o = (state==e_run) & queue_v_i & ~replay_v_i & ~redirect_v_i & (inflight < fifo_els_p). Combinational.
- yumi_o = issue_v_i & issue_en_o. An issue_v_i while issue_en_o=0 is ignored and sets error.
- deq_v_o = commit_v_i & (inflight != 0), in any state.
- Commit with inflight==0: no deq, sets error.
- roll_v_o = (state==e_roll). Registered, 1 cycle after the request.
- clr_v_o = (state==e_clr). Registered, held until ack.
- busy_o = (state!=e_run).
- Transitions:
  - e_run: redirect_v_i -> e_roll. replay_v_i -> e_roll, flagged replay-only. Redirect wins over replay in the same cycle.
  - e_roll: replay-only -> e_run; redirect -> e_clr. Exactly one cycle in this state.
  - e_clr: fe_ack_i -> e_run next cycle. fe_ack_i is sampled from the first e_clr cycle onward; an ack on the entry cycle gives a 1-cycle clr.
  - redirect_v_i in e_roll or e_clr restarts at e_roll and clears the replay-only flag.
  - replay_v_i outside e_run is ignored.
- Inflight counter:
  - In e_roll: inflight_n = 0. The queue's rptr jumps to cptr+deq, so commit and roll in the same cycle is legal.
  - Otherwise: inflight_n = inflight + yumi_o - deq_v_o. Simultaneous issue and commit leaves the count unchanged.
  - Saturation is impossible by construction: issue is gated at fifo_els_p and deq is gated at 0.
- Latency:
  - Replay: roll at t+1; issue_en_o can be high again at t+2.
  - Redirect: roll at t+1, clr from t+2 until ack, run the cycle after ack.
- error_o is sticky until reset.
- Reset during e_roll or e_clr returns immediately to e_run with all strobes low.

Decomposition:
- bp_be_pkg gets the typedef enum logic [1:0] {e_run, e_roll, e_clr} bp_be_fe_queue_ctrl_state_e.
- Queue-depth constants come from bp_params.
- Sub-module: bsg_counter_up_down for the inflight count (up=yumi_o, down=deq_v_o), with a synchronous clear on roll. All other logic is local: one state register plus the replay-only flag register.

Test Plan:
- Replay path: issue 3, commit 1, replay at cycle t -> roll_v_o=1 at t+1 only, inflight_o=0 at t+2, issue_en_o=1 at t+2.
- Redirect path: redirect at t, fe_ack_i at t+4 -> roll_v_o at t+1; clr_v_o at t+2..t+4; busy_o low and issue_en_o high at t+5.
- Commit during roll: inflight=4, commit_v_i=1 in the e_roll cycle -> deq_v_o=1 and roll_v_o=1 in that cycle, inflight_o=0 next.
- Issue limit (fifo_els_p=8): 8 issues, no commits -> issue_en_o=0 at inflight=8; one commit -> issue_en_o=1 the next cycle; extra issue_v_i while blocked -> yumi_o=0, error_o=1.
- Restart: redirect at t; second redirect at t+3 (in e_clr) -> roll_v_o re-asserts at t+4, clr_v_o from t+5.
- Reset mid-operation: assert reset_i in e_clr -> clr_v_o=0 and busy_o=0 immediately (async); error_o=0; inflight_o=0.
